// File: rtl/rijndael_pkg.sv
// Shared definitions for the Rijndael block loader and its helpers.
package rijndael_pkg;

  localparam int WORDSIZE = 32;

  typedef enum logic [1:0] {
    LOAD_STATE_LOAD,
    LOAD_STATE_ISSUE,
    LOAD_STATE_BUSY
  } loader_state_e;

endpackage

// File: rtl/rijndael_word_shifter.sv
// Shift-in register for a group of 32-bit words: the first word of a group
// ends up in the most significant position. The word counter either wraps
// at NWORDS (key, full flag set on wrap and dropped when a new group starts)
// or saturates at NWORDS (plaintext, cleared explicitly once consumed).
module rijndael_word_shifter
  import rijndael_pkg::*;
#(
  parameter int NWORDS = 4,
  parameter bit WRAP   = 1'b0,
  localparam int CW    = $clog2(NWORDS + 1),
  localparam int W     = WORDSIZE * NWORDS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift,
  input  logic                clear,
  input  logic [WORDSIZE-1:0] word,
  output logic [W-1:0]        data,
  output logic [CW-1:0]       count,
  output logic                full
);

  // Shift a word in from the right and track how many words the group holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      full  <= 1'b0;
    end else if (shift) begin
      data <= {data[W-WORDSIZE-1:0], word};
      if (WRAP) begin
        if (count == CW'(NWORDS - 1)) begin
          count <= '0;
          full  <= 1'b1;
        end else begin
          count <= count + 1'b1;
          if (count == '0) begin
            full <= 1'b0;
          end
        end
      end else begin
        if (count != CW'(NWORDS)) begin
          count <= count + 1'b1;
        end
        if (count == CW'(NWORDS - 1)) begin
          full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rijndael_block_loader.sv
// Feeder for the iterative encryption core: collects key and plaintext
// words from a valid/ready stream, launches the core with a single enable
// and keeps the operands frozen until the core is idle again. The key is
// kept between blocks so consecutive blocks only need fresh plaintext.
module rijndael_block_loader
  import rijndael_pkg::*;
#(
  parameter int NB         = 4,
  parameter int NK         = 4,
  localparam int STATESIZE = 32 * NB,
  localparam int KEYSIZE   = 32 * NK
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [31:0]          in_word_i,
  input  logic                 in_is_key_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 core_ready_i,
  output logic                 core_enable_o,
  output logic [STATESIZE-1:0] plaintext_o,
  output logic [KEYSIZE-1:0]   key_o,
  output logic                 key_valid_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int PCW = $clog2(NB + 1);
  localparam int KCW = $clog2(NK + 1);

  loader_state_e  state;
  logic [PCW-1:0] pt_cnt;
  logic [KCW-1:0] key_cnt;
  logic           pt_full;
  logic           accept;
  logic           key_shift;
  logic           pt_shift;
  logic           pt_clear;

  // Handshake and operand steering; words are only taken while loading.
  always_comb begin
    in_ready_o    = (state == LOAD_STATE_LOAD) && (in_is_key_i || (pt_cnt < PCW'(NB)));
    accept        = in_valid_i && in_ready_o;
    key_shift     = accept && in_is_key_i;
    pt_shift      = accept && !in_is_key_i;
    pt_clear      = (state == LOAD_STATE_BUSY) && core_ready_i;
    core_enable_o = (state == LOAD_STATE_ISSUE) && core_ready_i;
    busy_o        = (state == LOAD_STATE_BUSY);
  end

  rijndael_word_shifter #(
    .NWORDS(NK),
    .WRAP  (1'b1)
  ) u_key_shifter (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .shift(key_shift),
    .clear(1'b0),
    .word (in_word_i),
    .data (key_o),
    .count(key_cnt),
    .full (key_valid_o)
  );

  rijndael_word_shifter #(
    .NWORDS(NB),
    .WRAP  (1'b0)
  ) u_pt_shifter (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .shift(pt_shift),
    .clear(pt_clear),
    .word (in_word_i),
    .data (plaintext_o),
    .count(pt_cnt),
    .full (pt_full)
  );

  // Sequencing: wait for complete operands, hand them to the core, then
  // wait for the core to finish and report completion with a single pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= LOAD_STATE_LOAD;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        LOAD_STATE_LOAD: begin
          if (pt_full && key_valid_o && (key_cnt == '0)) begin
            state <= LOAD_STATE_ISSUE;
          end
        end
        LOAD_STATE_ISSUE: begin
          if (core_ready_i) begin
            state <= LOAD_STATE_BUSY;
          end
        end
        LOAD_STATE_BUSY: begin
          if (core_ready_i) begin
            state  <= LOAD_STATE_LOAD;
            done_o <= 1'b1;
          end
        end
        default: state <= LOAD_STATE_LOAD;
      endcase
    end
  end

endmodule
